// File: rtl/usb_wake_seq_if.sv
// Handshake bundle between the wake sequencer and the USB init/readout side.
// master = sequencer (drives wakeup and status), slave = init/readout side.
interface usb_wake_seq_if;
  logic       start;
  logic       suspend_req;
  logic       usb_clk_lock;
  logic       n_ready;
  logic       wakeup;
  logic       link_up;
  logic       busy;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;

  modport master (
    input  start, suspend_req, usb_clk_lock, n_ready,
    output wakeup, link_up, busy, fail, retry_cnt, state_o
  );

  modport slave (
    output start, suspend_req, usb_clk_lock, n_ready,
    input  wakeup, link_up, busy, fail, retry_cnt, state_o
  );
endinterface

// File: rtl/usb_wake_seq.sv
// USB clock bring-up initiator: wake pulse, lock/ready wait with timeouts and retries, suspend.
// Define LOCK_LOSS_RECOVERY_EN to re-run bring-up on lock loss in UP instead of entering FAIL.
module usb_wake_seq #(
  parameter int WAKE_LOW_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 1048576,
  parameter int READY_TIMEOUT   = 67108864,
  parameter int MAX_RETRY       = 3,
  parameter int CNT_W           = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  usb_wake_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAKE_PULSE = 3'd1,
    S_WAIT_LOCK  = 3'd2,
    S_WAIT_READY = 3'd3,
    S_UP         = 3'd4,
    S_SUSPEND    = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [4:0]       RETRY_LIM  = 5'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [1:0]       sync_q, sync_d;
  logic             wakeup_q, wakeup_d;
  logic             link_up_q, link_up_d;
  logic             busy_q, busy_d;
  logic             fail_q, fail_d;
  logic             attempt_fail;
  logic             lock_s;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    sync_d       = {sync_q[0], bus.usb_clk_lock};

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.suspend_req) begin
          retry_d = '0;
          state_d = S_WAKE_PULSE;
        end
      end
      S_WAKE_PULSE: begin
        if (!bus.start)              state_d = S_SUSPEND;
        else if (cnt_q == WAKE_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (!bus.start)              state_d = S_SUSPEND;
        else if (lock_s)             state_d = S_WAIT_READY;
        else if (cnt_q == LOCK_LAST) attempt_fail = 1'b1;
      end
      S_WAIT_READY: begin
        // Lock loss outranks a same-cycle ready indication.
        if (!bus.start)               state_d = S_SUSPEND;
        else if (!lock_s)             attempt_fail = 1'b1;
        else if (!bus.n_ready)        state_d = S_UP;
        else if (cnt_q == READY_LAST) attempt_fail = 1'b1;
      end
      S_UP: begin
        if (bus.suspend_req || !bus.start) begin
          state_d = S_SUSPEND;
        end else if (!lock_s || bus.n_ready) begin
`ifdef LOCK_LOSS_RECOVERY_EN
          retry_d = '0;
          state_d = S_WAKE_PULSE;
`else
          state_d = S_FAIL;
`endif
        end
      end
      S_SUSPEND: begin
        if (bus.n_ready || cnt_q == READY_LAST) state_d = S_IDLE;
      end
      S_FAIL: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (attempt_fail) begin
      if (retry_q != 4'hF) retry_d = retry_q + 4'd1;
      state_d = (({1'b0, retry_q} + 5'd1) < RETRY_LIM) ? S_WAKE_PULSE : S_FAIL;
    end

    // Counter restarts on every state entry, so timeouts are plain equality tests.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {S_WAKE_PULSE, S_WAIT_LOCK, S_WAIT_READY, S_SUSPEND}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    wakeup_d  = state_d inside {S_WAIT_LOCK, S_WAIT_READY, S_UP};
    link_up_d = (state_d == S_UP);
    busy_d    = state_d inside {S_WAKE_PULSE, S_WAIT_LOCK, S_WAIT_READY, S_SUSPEND};
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      sync_q    <= '0;
      wakeup_q  <= 1'b0;
      link_up_q <= 1'b0;
      busy_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      sync_q    <= sync_d;
      wakeup_q  <= wakeup_d;
      link_up_q <= link_up_d;
      busy_q    <= busy_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.wakeup    = wakeup_q;
  assign bus.link_up   = link_up_q;
  assign bus.busy      = busy_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_usb_wake_seq.sv
// Bench for usb_wake_seq: directed phases with randomized delays and retry patterns,
// expected timing derived from per-attempt durations.
module tb_usb_wake_seq;

  localparam int W  = 16;
  localparam int LT = 64;
  localparam int RT = 256;
  localparam int MR = 3;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  usb_wake_seq_if bus ();

  usb_wake_seq #(
    .WAKE_LOW_CYCLES(W),
    .LOCK_TIMEOUT   (LT),
    .READY_TIMEOUT  (RT),
    .MAX_RETRY      (MR),
    .CNT_W          (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles from entering a wake pulse until the next attempt starts (or UP for a good one).
  function automatic int dur(input int mode);
    if (mode == 0)      return W + LT;
    else if (mode == 1) return W + 3 + RT;
    else                return W + 4;
  endfunction

  // Full bring-up with lock arriving ld cycles after wakeup rises, ready rd cycles after that.
  task automatic bring_up(input int ld, input int rd);
    int n;
    bus.start = 1'b1;
    step(1);
    n = 0;
    while (!bus.wakeup && n < 100) begin step(1); n++; end
    chk("bu_wake_low", n, W);
    chk("bu_wait_lock_state", bus.state_o, 2);
    step(ld);
    bus.usb_clk_lock = 1'b1;
    n = 0;
    while (bus.state_o != 3'd3 && n < 100) begin step(1); n++; end
    chk("bu_lock_latency", n, 3);
    step(rd);
    bus.n_ready = 1'b0;
    n = 0;
    while (!bus.link_up && n < 300) begin step(1); n++; end
    chk("bu_up_latency", n, 1);
    chk("bu_up_state", bus.state_o, 4);
    chk("bu_up_retry", bus.retry_cnt, 0);
    chk("bu_up_wakeup", bus.wakeup, 1);
    chk("bu_up_busy", bus.busy, 0);
    $display("bring_up lock_dly=%0d rdy_dly=%0d link_up=%0d", ld, rd, bus.link_up);
  endtask

  // nfail failed attempts (lock timeout, or ready timeout if allow_rdy) before a good one.
  task automatic run_seq(input int nfail, input bit allow_rdy);
    int   mode[4];
    int   rise_t[4];
    int   rise_r[4];
    int   t_exp, t0, att, n, exp_att, exp_retry;
    logic wk_prev;
    bit   done;
    for (int i = 0; i < 4; i++) begin
      mode[i]   = (i < nfail) ? (allow_rdy ? int'($urandom_range(0, 1)) : 0) : 2;
      rise_t[i] = 0;
      rise_r[i] = 0;
    end
    exp_att   = (nfail < MR) ? nfail + 1 : MR;
    exp_retry = (nfail < MR) ? nfail : MR;
    t_exp = 0;
    for (int i = 0; i < exp_att; i++) t_exp += dur(mode[i]);

    bus.start = 1'b1;
    step(1);
    t0      = cyc;
    att     = 0;
    wk_prev = bus.wakeup;
    done    = 1'b0;
    n       = 0;
    while (!done && n < 3000) begin
      step(1);
      n++;
      if (bus.wakeup && !wk_prev && att < 4) begin
        rise_t[att]      = cyc;
        rise_r[att]      = int'(bus.retry_cnt);
        bus.usb_clk_lock = (mode[att] != 0);
        bus.n_ready      = (mode[att] == 2) ? 1'b0 : 1'b1;
        att++;
      end else if (!bus.wakeup && wk_prev) begin
        bus.usb_clk_lock = 1'b0;
        bus.n_ready      = 1'b1;
      end
      wk_prev = bus.wakeup;
      done    = bus.link_up || bus.fail;
    end
    chk("seq_done", done, 1);
    chk("seq_attempts", att, exp_att);
    chk("seq_first_wake", rise_t[0] - t0, W);
    for (int i = 1; i < att && i < 4; i++) begin
      chk("seq_attempt_spacing", rise_t[i] - rise_t[i-1], dur(mode[i-1]));
      chk("seq_retry_at_attempt", rise_r[i], i);
    end
    chk("seq_end_time", cyc - t0, t_exp);
    chk("seq_link_up", bus.link_up, (nfail < MR));
    chk("seq_fail", bus.fail, (nfail >= MR));
    chk("seq_retry", bus.retry_cnt, exp_retry);
    chk("seq_state", bus.state_o, (nfail < MR) ? 4 : 6);
    $display("seq nfail=%0d attempts=%0d cycles=%0d retry=%0d link_up=%0d", nfail, att,
             cyc - t0, bus.retry_cnt, bus.link_up);
    bus.start        = 1'b0;
    bus.usb_clk_lock = 1'b0;
    bus.n_ready      = 1'b1;
    step(3);
    chk("seq_back_idle", bus.state_o, 0);
  endtask

  initial begin
    int  n, k;
    bit  use_lock;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.suspend_req  = 1'b0;
    bus.usb_clk_lock = 1'b0;
    bus.n_ready      = 1'b1;

    // Reset state
    step(3);
    chk("rst_state", bus.state_o, 0);
    chk("rst_wakeup", bus.wakeup, 0);
    chk("rst_link_up", bus.link_up, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fail", bus.fail, 0);
    chk("rst_retry", bus.retry_cnt, 0);
    rst_n = 1'b1;
    step(2);
    chk("idle_hold", bus.state_o, 0);

    // Nominal bring-up then suspend
    bring_up($urandom_range(1, 50), $urandom_range(1, 150));
    k = $urandom_range(1, 10);
    step(k);
    chk("up_hold", bus.state_o, 4);
    bus.suspend_req = 1'b1;
    step(1);
    chk("susp_state", bus.state_o, 5);
    chk("susp_wakeup", bus.wakeup, 0);
    chk("susp_link_up", bus.link_up, 0);
    chk("susp_busy", bus.busy, 1);
    k = $urandom_range(1, 20);
    step(k);
    chk("susp_wait_ready", bus.state_o, 5);
    bus.n_ready = 1'b1;
    step(1);
    chk("susp_to_idle", bus.state_o, 0);
    chk("susp_idle_busy", bus.busy, 0);
    step(1);
    chk("idle_blocked_by_suspend", bus.state_o, 0);
    $display("suspend hold=%0d state=%0d", k, bus.state_o);
    bus.start        = 1'b0;
    bus.suspend_req  = 1'b0;
    bus.usb_clk_lock = 1'b0;
    step(3);

    // Lock timeout on every attempt
    run_seq(MR, 1'b0);

    // Lock loss in UP, via lock or via n_ready
    bring_up($urandom_range(1, 50), $urandom_range(1, 150));
    use_lock = 1'($urandom_range(0, 1));
    if (use_lock) bus.usb_clk_lock = 1'b0;
    else          bus.n_ready      = 1'b1;
    n = 0;
    while (bus.link_up && n < 10) begin step(1); n++; end
    chk("loss_latency", n, use_lock ? 3 : 1);
`ifdef LOCK_LOSS_RECOVERY_EN
    chk("loss_state", bus.state_o, 1);
    chk("loss_retry", bus.retry_cnt, 0);
    chk("loss_wakeup", bus.wakeup, 0);
    chk("loss_fail", bus.fail, 0);
    step(5 - n);
    bus.usb_clk_lock = 1'b1;
    bus.n_ready      = 1'b0;
    n = 0;
    while (!bus.link_up && n < 200) begin step(1); n++; end
    chk("loss_recovered", bus.link_up, 1);
    chk("loss_recovered_retry", bus.retry_cnt, 0);
    $display("lock_loss via_lock=%0d recovered link_up=%0d", use_lock, bus.link_up);
    bus.start        = 1'b0;
    bus.usb_clk_lock = 1'b0;
    bus.n_ready      = 1'b1;
    step(3);
`else
    chk("loss_state", bus.state_o, 6);
    chk("loss_fail", bus.fail, 1);
    chk("loss_link_up", bus.link_up, 0);
    step(5 - n);
    bus.usb_clk_lock = 1'b1;
    bus.n_ready      = 1'b0;
    step($urandom_range(5, 20));
    chk("loss_fail_sticky", bus.fail, 1);
    chk("loss_state_sticky", bus.state_o, 6);
    bus.start = 1'b0;
    step(1);
    chk("loss_exit_state", bus.state_o, 0);
    chk("loss_exit_fail", bus.fail, 0);
    $display("lock_loss via_lock=%0d fail cleared by start=0", use_lock);
    bus.usb_clk_lock = 1'b0;
    bus.n_ready      = 1'b1;
    step(3);
`endif
    chk("loss_back_idle", bus.state_o, 0);

    // Random retry patterns
    for (int it = 0; it < 6; it++) run_seq($urandom_range(0, MR), 1'b1);

    // Asynchronous reset in WAIT_LOCK
    bus.start = 1'b1;
    step(1 + W + $urandom_range(2, 40));
    chk("pre_rst_state", bus.state_o, 2);
    #($urandom_range(1, 7));
    rst_n = 1'b0;
    #1;
    chk("arst_state", bus.state_o, 0);
    chk("arst_wakeup", bus.wakeup, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_retry", bus.retry_cnt, 0);
    @(posedge clk);
    #1;
    step(2);
    rst_n = 1'b1;
    $display("async reset applied mid WAIT_LOCK, restarting");
    bring_up($urandom_range(1, 50), $urandom_range(1, 150));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_wake_seq.md
Name: usb_wake_seq

Overview:
Initiator side of the USB clock bring-up handshake. Drives the wakeup request into the init/reset block, then watches usb_clk_lock and n_ready. It enforces timeouts, retries a bounded number of times, and reports link state to the USB/readout logic. It also handles suspend: it drops wakeup and waits for the ready indication to deassert.

Parameters:
WAKE_LOW_CYCLES, 16, cycles wakeup is held low per bring-up attempt (min 1)
LOCK_TIMEOUT, 1048576, max cycles in WAIT_LOCK before the attempt fails
READY_TIMEOUT, 67108864, max cycles in WAIT_READY before the attempt fails (must exceed the init block's 2^25 ready delay)
MAX_RETRY, 3, failed attempts allowed before entering FAIL (1..15)
CNT_W, 32, width of the shared timeout counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  level; request link bring-up while high
suspend_req  input  1  level; request suspend while high
usb_clk_lock  input  1  PLL/DCM lock, asynchronous; double-flopped internally
n_ready  input  1  active-low ready from the init block, synchronous to clk
wakeup  output  1  to init block; low = hold/restart USB clock reset
link_up  output  1  high while in UP
busy  output  1  high in WAKE_PULSE, WAIT_LOCK, WAIT_READY, SUSPEND
fail  output  1  sticky high in FAIL
retry_cnt  output  4  failed attempts in the current bring-up
state_o  output  3  FSM state encoding for debug

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, wakeup=0, link_up=0, busy=0, fail=0, retry_cnt=0, counter=0, lock synchronizer=0.
- All outputs are registered; each changes on the clk edge that enters the corresponding state.
- State encoding: IDLE=0, WAKE_PULSE=1, WAIT_LOCK=2, WAIT_READY=3, UP=4, SUSPEND=5, FAIL=6.
- lock_s is usb_clk_lock after two flops (2-cycle latency). n_ready is used directly.
- IDLE: wakeup=0. When start=1 and suspend_req=0, clear retry_cnt and counter, then go to WAKE_PULSE.
- WAKE_PULSE: wakeup=0 for exactly WAKE_LOW_CYCLES cycles, counted from entry. Then set wakeup=1, clear counter, go to WAIT_LOCK.
- WAIT_LOCK: wakeup=1, counter increments each cycle.
  - lock_s=1: clear counter, go to WAIT_READY.
  - counter reaches LOCK_TIMEOUT-1 without lock: attempt failed.
- WAIT_READY: counter increments each cycle.
  - n_ready=0 and lock_s=1: go to UP.
  - lock_s=0: attempt failed; lock loss takes priority over a same-cycle n_ready=0.
  - counter reaches READY_TIMEOUT-1: attempt failed.
- Attempt failed:
  - retry_cnt+1 < MAX_RETRY: increment retry_cnt, go to WAKE_PULSE.
  - otherwise: increment retry_cnt, set fail=1, go to FAIL.
  - retry_cnt saturates at 15.
- UP: link_up=1, wakeup=1.
  - suspend_req=1 or start=0: go to SUSPEND.
  - lock_s=0 or n_ready=1: lock-loss handling (see Optional Feature).
  - If a suspend/stop request and lock loss occur in the same cycle, the request wins.
- SUSPEND: wakeup=0, link_up=0, counter increments.
  - Wait until n_ready=1, then go to IDLE.
  - Timeout at READY_TIMEOUT-1: go to IDLE anyway.
- FAIL: wakeup=0, fail=1.
  - Leave only when start=0, then go to IDLE and clear fail.
  - A reset also clears it.
- start falling during WAKE_PULSE, WAIT_LOCK or WAIT_READY: abort to SUSPEND. retry_cnt is left unchanged.
- The counter never wraps: comparisons are == and the counter is cleared on every state entry.

Optional Feature:
Macro LOCK_LOSS_RECOVERY_EN.
- Defined: lock loss in UP (lock_s=0 or n_ready=1 for one or more cycles) drops link_up on the next edge, clears retry_cnt and goes to WAKE_PULSE. This is an automatic re-bring-up with a fresh retry budget.
- Not defined: lock loss in UP sets fail=1, link_up=0 and goes to FAIL. Software must drop start to recover.

Test Plan:
- Nominal bring-up: WAKE_LOW_CYCLES=16. start=1; lock rises 50 cycles after wakeup rises; n_ready falls 100 cycles later.
  - Required: wakeup low exactly 16 cycles after start is sampled, link_up=1 one cycle after n_ready=0 is sampled, retry_cnt=0.
- Lock timeout with retries: LOCK_TIMEOUT=64, MAX_RETRY=3, lock held low.
  - Required: three wakeup low pulses spaced 16+64 cycles apart, then fail=1 and retry_cnt=3, state_o=6.
- Suspend: with link UP, assert suspend_req.
  - Required: wakeup=0 and link_up=0 on the next edge.
  - Required: after n_ready rises, state_o=0 on the next edge.
- Lock loss in UP: pulse lock low for 5 cycles.
  - Required with LOCK_LOSS_RECOVERY_EN: link_up drops 3 cycles after the lock pulse falls (2 sync flops plus 1 registered output) and the FSM re-enters WAKE_PULSE.
  - Required without LOCK_LOSS_RECOVERY_EN: fail=1, and it stays set until start=0.
- Reset mid-operation: drop rst_n during WAIT_LOCK, asynchronously to clk.
  - Required: wakeup=0, busy=0, state_o=0 immediately, without waiting for a clock edge.
  - Required: after release with start still 1, a full 16-cycle wake pulse is restarted.
